// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller.
// Holds the controller FSM state encoding, the MemSrc and MemDst code points,
// the requester index constants and two small selection helpers.
// Requester indices double as bit positions in request/ack vectors:
//   bit 0 = data, bit 1 = stack, bit 2 = fetch.
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  localparam int NUM_REQ = 3;

  localparam logic [1:0] REQ_DATA  = 2'd0;
  localparam logic [1:0] REQ_STACK = 2'd1;
  localparam logic [1:0] REQ_FETCH = 2'd2;

  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_SP  = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  localparam logic [2:0] DST_NONE    = 3'b000;
  localparam logic [2:0] DST_MARY    = 3'b001;
  localparam logic [2:0] DST_SHELLEY = 3'b010;
  localparam logic [2:0] DST_COMP    = 3'b011;
  localparam logic [2:0] DST_RA      = 3'b100;

  // Address source used by each requester.
  function automatic logic [1:0] src_of(logic [1:0] idx);
    logic [1:0] src;
    case (idx)
      REQ_DATA:  src = SRC_REG;
      REQ_STACK: src = SRC_SP;
      default:   src = SRC_PC;
    endcase
    return src;
  endfunction

  // Lowest set index wins, which makes data > stack > fetch.
  function automatic logic [1:0] first_set(logic [NUM_REQ-1:0] v);
    logic [1:0] pick;
    if (v[0])      pick = REQ_DATA;
    else if (v[1]) pick = REQ_STACK;
    else if (v[2]) pick = REQ_FETCH;
    else           pick = REQ_DATA;
    return pick;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester handshake and memory bus bundle for mem_access_ctrl.
//   requests : fetch_req, stack_req/stack_push, data_req/data_we/data_dst
//   acks     : fetch_ack, stack_ack, data_ack (one-cycle pulses)
//   memory   : MemSrc, MemRead, MemWrite, MemDst
//   enables  : MaryWrite, ShelleyWrite, CompWrite, RAWrite
//   status   : busy
// master = requester/environment side, slave = controller side.
interface mem_access_ctrl_if;
  logic       fetch_req;
  logic       stack_req;
  logic       stack_push;
  logic       data_req;
  logic       data_we;
  logic [2:0] data_dst;
  logic       fetch_ack;
  logic       stack_ack;
  logic       data_ack;
  logic [1:0] MemSrc;
  logic       MemRead;
  logic       MemWrite;
  logic [2:0] MemDst;
  logic       MaryWrite;
  logic       ShelleyWrite;
  logic       CompWrite;
  logic       RAWrite;
  logic       busy;

  modport master (
    output fetch_req, stack_req, stack_push, data_req, data_we, data_dst,
    input  fetch_ack, stack_ack, data_ack, MemSrc, MemRead, MemWrite, MemDst,
    input  MaryWrite, ShelleyWrite, CompWrite, RAWrite, busy
  );

  modport slave (
    input  fetch_req, stack_req, stack_push, data_req, data_we, data_dst,
    output fetch_ack, stack_ack, data_ack, MemSrc, MemRead, MemWrite, MemDst,
    output MaryWrite, ShelleyWrite, CompWrite, RAWrite, busy
  );
endinterface

// File: rtl/mem_access_arb.sv
// Winner selection for the memory access controller.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   req            : pending requests (bit 0 data, 1 stack, 2 fetch)
//   grant_take     : high on the edge where the controller accepts winner
//   winner         : combinational index of the requester to serve
// Build option MEM_ACCESS_RR_EN: round-robin rotation data -> stack -> fetch.
// Without it: fixed priority data > stack > fetch, with per-requester loss
// counters that force a grant once a requester has lost STALL_MAX times.
module mem_access_arb
  import mem_access_ctrl_pkg::*;
#(
  parameter int STALL_MAX = 15
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_take,
  output logic [1:0]         winner
);

`ifdef MEM_ACCESS_RR_EN
  logic [1:0] last_reg;

  // Search starts just after the previous winner; the previous winner itself
  // is tried last.
  function automatic logic [1:0] rr_pick(logic [NUM_REQ-1:0] r, logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] cand;
    int         c;
    pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      c = int'(last) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      cand = 2'(c);
      if (r[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_reg);

  // Reset to fetch so that data is first in line after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        last_reg <= REQ_FETCH;
    else if (grant_take) last_reg <= winner;
  end
`else
  localparam logic [3:0] STALL_LIM = 4'(STALL_MAX);

  logic [NUM_REQ-1:0] starved;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_loss
      logic [3:0] loss_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          loss_reg <= '0;
        end else if (grant_take) begin
          if (winner == 2'(gi))
            loss_reg <= '0;
          else if (req[gi] && (loss_reg != STALL_LIM))
            loss_reg <= loss_reg + 4'd1;
        end
      end

      assign starved[gi] = req[gi] && (loss_reg == STALL_LIM);
    end
  endgenerate

  // A starved requester overrides normal priority; ties among starved
  // requesters still resolve data > stack > fetch.
  assign winner = (|starved) ? first_set(starved) : first_set(req);
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates instruction fetch, stack and data
// requests onto a single memory port, one transaction at a time.
// Ports:
//   clock   : system clock, all state on rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mem_access_ctrl_if.slave (requests, acks, memory strobes,
//             destination enables, busy)
// Parameters: READ_LAT (1..3) cycles from MemRead to data, STALL_MAX loss
// limit for the anti-starvation logic.
// Build option MEM_ACCESS_RR_EN selects round-robin arbitration (see
// mem_access_arb).
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int READ_LAT  = 1,
  parameter int STALL_MAX = 15
) (
  input logic                 clock,
  input logic                 reset_n,
  mem_access_ctrl_if.slave    bus
);

  state_t             state_reg, state_next;
  logic [1:0]         win_reg, win_next;
  logic               we_reg, we_next;
  logic [2:0]         dst_reg, dst_next;
  logic [1:0]         wait_reg, wait_next;

  logic [NUM_REQ-1:0] req_vec;
  logic               grant_take;
  logic [1:0]         winner;

  logic [1:0]         mem_src;
  logic               mem_read, mem_write;
  logic [2:0]         mem_dst;
  logic [3:0]         wr_en;    // {Mary, Shelley, Comp, RA}
  logic [2:0]         ack_vec;  // {fetch, stack, data}

  assign req_vec    = {bus.fetch_req, bus.stack_req, bus.data_req};
  assign grant_take = (state_reg == ST_IDLE) && (|req_vec);

  mem_access_arb #(
    .STALL_MAX (STALL_MAX)
  ) u_arb (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req_vec),
    .grant_take (grant_take),
    .winner     (winner)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      win_reg   <= REQ_DATA;
      we_reg    <= 1'b0;
      dst_reg   <= DST_NONE;
      wait_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      win_reg   <= win_next;
      we_reg    <= we_next;
      dst_reg   <= dst_next;
      wait_reg  <= wait_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    win_next   = win_reg;
    we_next    = we_reg;
    dst_next   = dst_reg;
    wait_next  = wait_reg;
    mem_src    = SRC_PC;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_dst    = DST_NONE;
    wr_en      = 4'b0000;
    ack_vec    = 3'b000;

    case (state_reg)
      ST_IDLE: begin
        if (grant_take) begin
          // The whole command is captured here, so a requester may drop its
          // request mid-transaction without affecting it.
          win_next   = winner;
          state_next = ST_ISSUE;
          case (winner)
            REQ_DATA: begin
              we_next  = bus.data_we;
              dst_next = bus.data_we ? DST_NONE : bus.data_dst;
            end
            REQ_STACK: begin
              we_next  = bus.stack_push;
              dst_next = bus.stack_push ? DST_NONE : DST_RA;
            end
            default: begin
              // Fetch lands in the instruction register, which has no enable here.
              we_next  = 1'b0;
              dst_next = DST_NONE;
            end
          endcase
        end
      end

      ST_ISSUE: begin
        mem_src = src_of(win_reg);
        if (we_reg) begin
          mem_write  = 1'b1;
          ack_vec    = 3'b001 << win_reg;
          state_next = ST_IDLE;
        end else begin
          mem_read = 1'b1;
          if (READ_LAT > 1) begin
            state_next = ST_WAIT;
            wait_next  = 2'(READ_LAT - 2);
          end else begin
            state_next = ST_CAPTURE;
          end
        end
      end

      ST_WAIT: begin
        mem_src  = src_of(win_reg);
        mem_read = 1'b1;
        if (wait_reg == 2'd0) state_next = ST_CAPTURE;
        else                  wait_next  = wait_reg - 2'd1;
      end

      ST_CAPTURE: begin
        mem_src    = src_of(win_reg);
        mem_dst    = dst_reg;
        wr_en      = {dst_reg == DST_MARY, dst_reg == DST_SHELLEY,
                      dst_reg == DST_COMP, dst_reg == DST_RA};
        ack_vec    = 3'b001 << win_reg;
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.MemSrc       = mem_src;
  assign bus.MemRead      = mem_read;
  assign bus.MemWrite     = mem_write;
  assign bus.MemDst       = mem_dst;
  assign bus.MaryWrite    = wr_en[3];
  assign bus.ShelleyWrite = wr_en[2];
  assign bus.CompWrite    = wr_en[1];
  assign bus.RAWrite      = wr_en[0];
  assign bus.data_ack     = ack_vec[0];
  assign bus.stack_ack    = ack_vec[1];
  assign bus.fetch_ack    = ack_vec[2];
  assign bus.busy         = (state_reg != ST_IDLE);

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: READ_LAT, 1, cycles from MemRead to valid mem_out (legal 1..3).
REQ-002 Parameter: STALL_MAX, 15, max consecutive losses before a requester is force-granted (width 4).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 fetch_req  in  1  instruction fetch request (address = pc, dest = instruction reg).
REQ-007 stack_req, stack_push  in  1,1  stack access request; push=1 write, 0 pop/read (address = sp_in).
REQ-008 data_req, data_we  in  1,1  load/store request (address = reg_in).
REQ-009 data_dst  in  3  MemDst code for load destination (000 none, 001 Mary, 010 Shelley, 011 Comp, 100 RA).
REQ-010 fetch_ack, stack_ack, data_ack  out  1 each  one-cycle completion pulse per requester.
REQ-011 MemSrc  out  2  00 pc, 01 sp, 10 reg, 11 unused.
REQ-012 MemRead, MemWrite  out  1,1  memory strobes.
REQ-013 MemDst  out  3  destination code during capture.
REQ-014 MaryWrite, ShelleyWrite, CompWrite, RAWrite  out  1 each  destination write enables, one-hot or all zero.
REQ-015 busy  out  1  high whenever FSM not IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT, CAPTURE; one transaction at a time.
REQ-017 IDLE: if any req high, latch winner and its command next edge, go ISSUE; else stay.
REQ-018 Fixed priority data > stack > fetch (default build).
REQ-019 ISSUE (1 cycle): MemSrc per winner; write -> MemWrite=1, ack pulse this cycle, return IDLE; read -> MemRead=1, go WAIT.
REQ-020 WAIT lasts READ_LAT-1 cycles (zero for READ_LAT=1), MemRead held high, MemSrc held.
REQ-021 CAPTURE (1 cycle): MemDst = latched dest, matching write enable high, ack pulse, return IDLE.
REQ-022 Fetch read dest forced 000 with no write enable; stack pop dest 100 (RA); data load dest = data_dst.
REQ-023 Requests are level; requester holds req until ack; deassert before ack is ignored, transaction completes and ack still pulses.
REQ-024 Simultaneous requests: winner served; losers stay pending, served on subsequent IDLE arbitrations; back-to-back throughput one write per 2 cycles.
REQ-025 Outside ISSUE/WAIT/CAPTURE all strobes, enables, acks 0; MemSrc 00; MemDst 000.
REQ-026 Never MemRead and MemWrite high in same cycle; never more than one ack per cycle.
REQ-027 Per-requester loss counter saturates at STALL_MAX; at STALL_MAX that requester wins next arbitration regardless of priority, counter clears on its grant.

Reset
REQ-028 reset_n low: state IDLE, all outputs 0, MemSrc 00, counters 0, latched command cleared, immediately (asynchronous).
REQ-029 Reset mid-transaction aborts it with no ack; first arbitration is the first rising edge after reset_n release.

Configuration
REQ-030 MEM_ACCESS_RR_EN defined: round-robin among pending requesters, pointer advances past last winner, STALL_MAX logic removed; undefined: fixed priority plus REQ-027 anti-starvation.

Structure
REQ-031 Shared package holds FSM state enum, MemSrc codes, MemDst codes, requester index constants.
REQ-032 One sub-module mem_access_arb: combinational/registered winner select (priority or RR), instantiated once.

Verification
REQ-033 Data store alone (data_req=1, data_we=1): MemSrc=10, MemWrite=1 one cycle after request, data_ack same cycle, back in IDLE next.
REQ-034 Fetch read, READ_LAT=2: MemRead high 2 cycles, CAPTURE cycle MemDst=000, no write enable, fetch_ack once.
REQ-035 data load dst=001, stack pop, fetch all asserted together: order data (MaryWrite), stack (RAWrite, MemDst=100), fetch; three acks, never overlapping.
REQ-036 Data held continuously plus fetch: fetch granted after exactly 15 data losses (default build).
REQ-037 reset_n low during WAIT: outputs 0 asynchronously, no ack; after release, pending fetch restarts from ISSUE.
REQ-038 MEM_ACCESS_RR_EN build, all three held: grants rotate data, stack, fetch, data...
